// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - opcodes, sequencer states and opcode classes for the hardwired control unit
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    CL_ALU_R, CL_ALU_I, CL_LDI, CL_LD, CL_ST, CL_BR, CL_JR, CL_NOP, CL_HALT
  } op_class_t;

  typedef enum logic [1:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR
  } alu_op_t;

endpackage

// File: rtl/ctrl_opcode_decode.sv
// rtl/ctrl_opcode_decode.sv - maps a 5-bit opcode to its class and ALU operation
module ctrl_opcode_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] i_opcode,
  output op_class_t  o_class,
  output alu_op_t    o_alu_op
);

  always_comb begin
    o_class  = CL_NOP;
    o_alu_op = ALU_ADD;
    case (i_opcode)
      OP_LD:   o_class = CL_LD;
      OP_LDI:  o_class = CL_LDI;
      OP_ST:   o_class = CL_ST;
      OP_ADD:  o_class = CL_ALU_R;
      OP_SUB:  begin o_class = CL_ALU_R; o_alu_op = ALU_SUB; end
      OP_AND:  begin o_class = CL_ALU_R; o_alu_op = ALU_AND; end
      OP_OR:   begin o_class = CL_ALU_R; o_alu_op = ALU_OR;  end
      OP_ADDI: o_class = CL_ALU_I;
      OP_ANDI: begin o_class = CL_ALU_I; o_alu_op = ALU_AND; end
      OP_ORI:  begin o_class = CL_ALU_I; o_alu_op = ALU_OR;  end
      OP_BR:   o_class = CL_BR;
      OP_JR:   o_class = CL_JR;
      OP_HALT: o_class = CL_HALT;
      // nop and every unassigned opcode fall through to CL_NOP
      default: o_class = CL_NOP;
    endcase
  end

endmodule

// File: rtl/hardwired_control_unit.sv
// rtl/hardwired_control_unit.sv - fetch/decode/execute sequencer driving the datapath strobes
module hardwired_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        CON,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        MD_read,
  output logic        Read,
  output logic        Write,
  output logic        IRin,
  output logic        Yin,
  output logic        Zlowin,
  output logic        Zlowout,
  output logic        Csignout,
  output logic        CONin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        ADD,
  output logic        SUB,
  output logic        AND,
  output logic        OR,
  output logic        Run
);

  state_t    r_state, w_next;
  op_class_t r_class, w_class;
  alu_op_t   r_alu, w_alu;
  logic [2:0] r_wait;
  logic       w_mem_step, w_wait_done;
  logic [3:0] w_alu_sel;
  logic       w_unused_ir;

  assign w_unused_ir = ^IR[26:0];

  ctrl_opcode_decode u_decode (
    .i_opcode (IR[31:27]),
    .o_class  (w_class),
    .o_alu_op (w_alu)
  );

  // Memory-read steps stretch over 1+MEM_WAIT cycles; every other step is one cycle.
  assign w_mem_step  = (r_state == S_T1) || (r_state == S_T6 && r_class == CL_LD);
  assign w_wait_done = (r_wait == MEM_WAIT[2:0]);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state <= S_RST;
      r_wait  <= '0;
      r_class <= CL_NOP;
      r_alu   <= ALU_ADD;
    end else begin
      r_state <= w_next;
      r_wait  <= (w_mem_step && !w_wait_done) ? r_wait + 3'd1 : 3'd0;
      if (r_state == S_T2) begin
        r_class <= w_class;
        r_alu   <= w_alu;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RST: w_next = S_T0;
      S_T0:  w_next = S_T1;
      S_T1:  w_next = w_wait_done ? S_T2 : S_T1;
      S_T2:  w_next = S_T3;
      S_T3: begin
        case (r_class)
          CL_JR, CL_NOP: w_next = S_T0;
          CL_HALT:       w_next = S_HALT;
          default:       w_next = S_T4;
        endcase
      end
      S_T4:  w_next = S_T5;
      S_T5:  w_next = (r_class == CL_LD || r_class == CL_ST || r_class == CL_BR) ? S_T6 : S_T0;
      S_T6: begin
        if (r_class == CL_LD) w_next = w_wait_done ? S_T7 : S_T6;
        else if (r_class == CL_ST) w_next = S_T7;
        else w_next = S_T0;
      end
      S_T7:   w_next = S_T0;
      S_HALT: w_next = S_HALT;
      default: w_next = S_RST;
    endcase
  end

  always_comb begin
    w_alu_sel = 4'b0001;
    case (r_alu)
      ALU_SUB: w_alu_sel = 4'b0010;
      ALU_AND: w_alu_sel = 4'b0100;
      ALU_OR:  w_alu_sel = 4'b1000;
      default: w_alu_sel = 4'b0001;
    endcase
  end

  always_comb begin
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0; MDRin = 1'b0;
    MDRout = 1'b0; MD_read = 1'b0; Read = 1'b0; Write = 1'b0; IRin = 1'b0;
    Yin = 1'b0; Zlowin = 1'b0; Zlowout = 1'b0; Csignout = 1'b0; CONin = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    ADD = 1'b0; SUB = 1'b0; AND = 1'b0; OR = 1'b0;
    Run = 1'b0;
    case (r_state)
      S_T0: begin Run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1; end
      S_T1: begin Run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MD_read = 1'b1; MDRin = 1'b1; end
      S_T2: begin Run = 1'b1; MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        Run = 1'b1;
        case (r_class)
          CL_ALU_R, CL_ALU_I: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          CL_LDI, CL_LD, CL_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          CL_BR: begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          CL_JR: begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        Run = 1'b1;
        case (r_class)
          CL_ALU_R: begin Grc = 1'b1; Rout = 1'b1; Zlowin = 1'b1; {OR, AND, SUB, ADD} = w_alu_sel; end
          CL_ALU_I: begin Csignout = 1'b1; Zlowin = 1'b1; {OR, AND, SUB, ADD} = w_alu_sel; end
          CL_LDI, CL_LD, CL_ST: begin Csignout = 1'b1; ADD = 1'b1; Zlowin = 1'b1; end
          CL_BR: begin PCout = 1'b1; Yin = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        Run = 1'b1;
        case (r_class)
          CL_ALU_R, CL_ALU_I, CL_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CL_LD, CL_ST: begin Zlowout = 1'b1; MARin = 1'b1; end
          CL_BR: begin Csignout = 1'b1; ADD = 1'b1; Zlowin = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        Run = 1'b1;
        case (r_class)
          CL_LD: begin Read = 1'b1; MD_read = 1'b1; MDRin = 1'b1; end
          CL_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          // the only Mealy output: the branch is taken only while CON holds
          CL_BR: begin Zlowout = 1'b1; PCin = CON; end
          default: ;
        endcase
      end
      S_T7: begin
        Run = 1'b1;
        case (r_class)
          CL_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CL_ST: Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hardwired_control_unit.sv
// tb/tb_hardwired_control_unit.sv - self-checking bench for hardwired_control_unit
module tb_hardwired_control_unit;

  localparam int MW = 2;

  localparam logic [25:0] K_PCOUT   = 26'd1 << 0;
  localparam logic [25:0] K_PCIN    = 26'd1 << 1;
  localparam logic [25:0] K_INCPC   = 26'd1 << 2;
  localparam logic [25:0] K_MARIN   = 26'd1 << 3;
  localparam logic [25:0] K_MDRIN   = 26'd1 << 4;
  localparam logic [25:0] K_MDROUT  = 26'd1 << 5;
  localparam logic [25:0] K_MDREAD  = 26'd1 << 6;
  localparam logic [25:0] K_READ    = 26'd1 << 7;
  localparam logic [25:0] K_WRITE   = 26'd1 << 8;
  localparam logic [25:0] K_IRIN    = 26'd1 << 9;
  localparam logic [25:0] K_YIN     = 26'd1 << 10;
  localparam logic [25:0] K_ZLOWIN  = 26'd1 << 11;
  localparam logic [25:0] K_ZLOWOUT = 26'd1 << 12;
  localparam logic [25:0] K_CSIGN   = 26'd1 << 13;
  localparam logic [25:0] K_CONIN   = 26'd1 << 14;
  localparam logic [25:0] K_GRA     = 26'd1 << 15;
  localparam logic [25:0] K_GRB     = 26'd1 << 16;
  localparam logic [25:0] K_GRC     = 26'd1 << 17;
  localparam logic [25:0] K_RIN     = 26'd1 << 18;
  localparam logic [25:0] K_ROUT    = 26'd1 << 19;
  localparam logic [25:0] K_BAOUT   = 26'd1 << 20;
  localparam logic [25:0] K_ADD     = 26'd1 << 21;
  localparam logic [25:0] K_SUB     = 26'd1 << 22;
  localparam logic [25:0] K_AND     = 26'd1 << 23;
  localparam logic [25:0] K_OR      = 26'd1 << 24;
  localparam logic [25:0] K_RUN     = 26'd1 << 25;
  localparam logic [25:0] K_BUS = K_PCOUT | K_ZLOWOUT | K_MDROUT | K_ROUT | K_BAOUT | K_CSIGN;
  localparam logic [25:0] K_ALU = K_ADD | K_SUB | K_AND | K_OR;

  logic clock = 1'b0;
  logic clear = 1'b0;
  logic [31:0] IR = 32'd0;
  logic CON = 1'b0;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, MD_read, Read, Write, IRin;
  logic Yin, Zlowin, Zlowout, Csignout, CONin;
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic ADD, SUB, AND, OR, Run;

  hardwired_control_unit #(.MEM_WAIT(MW)) dut (
    .clock(clock), .clear(clear), .IR(IR), .CON(CON),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .MD_read(MD_read), .Read(Read), .Write(Write), .IRin(IRin),
    .Yin(Yin), .Zlowin(Zlowin), .Zlowout(Zlowout), .Csignout(Csignout), .CONin(CONin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .Run(Run)
  );

  always #5 clock = ~clock;

  logic [25:0] obs;
  assign obs = {Run, OR, AND, SUB, ADD, BAout, Rout, Rin, Grc, Grb, Gra, CONin, Csignout,
                Zlowout, Zlowin, Yin, IRin, Write, Read, MD_read, MDRout, MDRin, MARin,
                IncPC, PCin, PCout};

  int n_cmp = 0;
  int n_bad = 0;
  logic [25:0] exp_q[$];
  logic [4:0] op_tab[14] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
                             5'b00110, 5'b01100, 5'b01101, 5'b01110, 5'b10010, 5'b10011,
                             5'b11010, 5'b11111};

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic step(input logic [25:0] v, input int n);
    repeat (n) exp_q.push_back(v | K_RUN);
  endtask

  // Expected per-cycle strobe vectors for one instruction, straight from the step tables.
  task automatic build(input logic [4:0] op, input logic con);
    logic [25:0] aop;
    exp_q.delete();
    step(K_PCOUT | K_MARIN | K_INCPC | K_ZLOWIN, 1);
    step(K_ZLOWOUT | K_PCIN | K_READ | K_MDREAD | K_MDRIN, 1 + MW);
    step(K_MDROUT | K_IRIN, 1);
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
        aop = (op == 5'b00011) ? K_ADD : (op == 5'b00100) ? K_SUB : (op == 5'b00101) ? K_AND : K_OR;
        step(K_GRB | K_ROUT | K_YIN, 1);
        step(K_GRC | K_ROUT | aop | K_ZLOWIN, 1);
        step(K_ZLOWOUT | K_GRA | K_RIN, 1);
      end
      5'b01100, 5'b01101, 5'b01110: begin
        aop = (op == 5'b01100) ? K_ADD : (op == 5'b01101) ? K_AND : K_OR;
        step(K_GRB | K_ROUT | K_YIN, 1);
        step(K_CSIGN | aop | K_ZLOWIN, 1);
        step(K_ZLOWOUT | K_GRA | K_RIN, 1);
      end
      5'b00001: begin
        step(K_GRB | K_BAOUT | K_YIN, 1);
        step(K_CSIGN | K_ADD | K_ZLOWIN, 1);
        step(K_ZLOWOUT | K_GRA | K_RIN, 1);
      end
      5'b00000, 5'b00010: begin
        step(K_GRB | K_BAOUT | K_YIN, 1);
        step(K_CSIGN | K_ADD | K_ZLOWIN, 1);
        step(K_ZLOWOUT | K_MARIN, 1);
        if (op == 5'b00000) begin
          step(K_READ | K_MDREAD | K_MDRIN, 1 + MW);
          step(K_MDROUT | K_GRA | K_RIN, 1);
        end else begin
          step(K_GRA | K_ROUT | K_MDRIN, 1);
          step(K_WRITE, 1);
        end
      end
      5'b10010: begin
        step(K_GRA | K_ROUT | K_CONIN, 1);
        step(K_PCOUT | K_YIN, 1);
        step(K_CSIGN | K_ADD | K_ZLOWIN, 1);
        step(K_ZLOWOUT | (con ? K_PCIN : 26'd0), 1);
      end
      5'b10011: step(K_GRA | K_ROUT | K_PCIN, 1);
      default: step(26'd0, 1);
    endcase
  endtask

  task automatic run_instr(input logic [31:0] ir, input logic con, input int abort_at);
    IR  = ir;
    CON = con;
    build(ir[31:27], con);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clock); #1;
      chk($sformatf("op%b_step%0d", ir[31:27], i), 32'(obs), 32'(exp_q[i]));
      chk($sformatf("op%b_step%0d_onehot", ir[31:27], i),
          32'(($countones(obs & K_BUS) <= 1) && ($countones(obs & K_ALU) <= 1)), 32'd1);
      if (i == 3 + MW) IR = $urandom;
      if (i == abort_at) begin
        #1 clear = 1'b0;
        #1 chk("abort_async_zero", 32'(obs), 32'd0);
        repeat (3) begin
          @(posedge clock); #1;
          chk("abort_hold_zero", 32'(obs), 32'd0);
        end
        @(negedge clock) clear = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    repeat (3) begin
      @(posedge clock); #1;
      chk("reset_zero", 32'(obs), 32'd0);
    end
    @(negedge clock) clear = 1'b1;
    #1 chk("rst_after_release", 32'(obs), 32'd0);

    run_instr(32'h6127FFFB, 1'b0, -1);
    run_instr({5'b00000, 27'($urandom)}, 1'b0, -1);
    run_instr({5'b10010, 27'($urandom)}, 1'b0, -1);
    run_instr({5'b10010, 27'($urandom)}, 1'b1, -1);
    run_instr({5'b00010, 27'($urandom)}, 1'b0, 6 + MW);

    for (int n = 0; n < 40; n++)
      run_instr({op_tab[$urandom_range(0, 13)], 27'($urandom)}, 1'($urandom), -1);

    run_instr({5'b11011, 27'($urandom)}, 1'b0, -1);
    repeat (4) begin
      @(posedge clock); #1;
      chk("halt_stuck", 32'(obs), 32'd0);
    end
    @(negedge clock) clear = 1'b0;
    @(negedge clock) clear = 1'b1;
    run_instr({5'b11111, 27'($urandom)}, 1'b1, -1);
    run_instr({5'b00011, 27'($urandom)}, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hardwired_control_unit.md
Name: hardwired_control_unit

Overview:
Hardwired control sequencer for the bus-based datapath (DataPath). It produces, from the instruction in IR, the per-step control strobes that directed benches currently drive by hand: fetch, decode and execute sequences. It replaces the bench stimulus in CPU top-level simulations.

Parameters:
MEM_WAIT, 0, extra cycles that every memory-read step holds Read/MD_read/MDRin (0..7).

Ports:
clock  in  1  system clock; all state changes on its rising edge.
clear  in  1  asynchronous, active-low reset.
IR  in  32  instruction register contents.
CON  in  1  branch-condition flip-flop output from the datapath.
PCout, PCin, IncPC, MARin, MDRin, MDRout, MD_read, Read, Write, IRin  out  1 each  fetch and memory strobes.
Yin, Zlowin, Zlowout, Csignout, CONin  out  1 each  ALU and branch strobes.
Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-select strobes.
ADD, SUB, AND, OR  out  1 each  ALU operation selects.
Run  out  1  1 while executing, 0 in reset and halt.

Behaviour:
- Opcode = IR[31:27]. Opcode values:
  - ld 00000, ldi 00001, st 00010
  - add 00011, sub 00100, and 00101, or 00110
  - addi 01100, andi 01101, ori 01110
  - br 10010, jr 10011, nop 11010, halt 11011
  - Any other opcode executes as nop.
- States: RST, T0..T7, HALT. Outputs are a Moore decode of state and the latched opcode class. The one exception is PCin in br T6, which is gated combinationally by CON.
- Reset: clear=0 forces state RST asynchronously. In RST every output is 0, including Run. The first rising edge with clear=1 moves the state to T0.
- Reset mid-instruction: all strobes drop to 0 immediately; no partial write completes after clear falls.
- Each step asserts its strobes for exactly one cycle, then advances. The only exceptions are memory-read steps, which last 1+MEM_WAIT cycles counted by a wait counter that restarts at 0 on step entry.
- Run = 1 in T0..T7.
- Fetch (all instructions):
  - T0: PCout MARin IncPC Zlowin
  - T1 (memory read): Zlowout PCin Read MD_read MDRin
  - T2: MDRout IRin
  - Opcode is captured from IR at the end of T2; IR changes after T2 do not alter the running sequence.
- add/sub/and/or:
  - T3: Grb Rout Yin
  - T4: Grc Rout <op> Zlowin
  - T5: Zlowout Gra Rin, then T0
- addi/andi/ori:
  - T3: Grb Rout Yin
  - T4: Csignout <op> Zlowin (addi uses ADD, andi AND, ori OR)
  - T5: Zlowout Gra Rin, then T0
- ldi:
  - T3: Grb BAout Yin
  - T4: Csignout ADD Zlowin
  - T5: Zlowout Gra Rin, then T0
- ld:
  - T3..T4 as ldi
  - T5: Zlowout MARin
  - T6 (memory read): Read MD_read MDRin
  - T7: MDRout Gra Rin, then T0
- st:
  - T3..T5 as ld
  - T6: Gra Rout MDRin (MD_read=0)
  - T7: Write, then T0
- br:
  - T3: Gra Rout CONin
  - T4: PCout Yin
  - T5: Csignout ADD Zlowin
  - T6: Zlowout, plus PCin only if CON=1 during T6; then T0
- jr: T3: Gra Rout PCin, then T0.
- nop / illegal opcode: T3 with no strobes, then T0.
- halt: T3 with no strobes, then HALT. HALT keeps all outputs 0 with Run=0 until clear falls.
- Mutual exclusion: at most one bus driver is high per cycle (PCout, Zlowout, MDRout, Rout, BAout, Csignout); at most one ALU op select is high.

Decomposition:
- cpu_ctrl_pkg holds the opcode constants, the state enum (RST, T0..T7, HALT) and the opcode-class enum (ALU_R, ALU_I, LDI, LD, ST, BR, JR, NOP, HALT).
- One combinational sub-module, ctrl_opcode_decode, maps opcode to class and ALU op select. The sequencer and the strobe decode stay in hardwired_control_unit.

Test Plan:
1. Hold clear=0 for 3 cycles, then release -> all strobes 0 and Run=0 during reset; the first posedge after release enters T0 with PCout=MARin=IncPC=Zlowin=1.
2. IR=0x6127FFFB (addi R2,R4,-5) -> T3 Grb+Rout+Yin, T4 Csignout+ADD+Zlowin, T5 Zlowout+Gra+Rin; back to T0 after 6 cycles total.
3. ld with MEM_WAIT=2 -> T1 and T6 each hold Read=MD_read=MDRin=1 for exactly 3 cycles; the instruction takes 12 cycles.
4. br with CON=0, then the same br with CON=1 -> PCin stays 0 in T6 for the first and is 1 for exactly one cycle in T6 for the second.
5. Assert clear=0 during st T6 -> Write is never asserted and all outputs go 0 asynchronously.
6. IR opcode 11011 (halt), then 11111 (illegal) after reset -> Run=0 and outputs stuck at 0 until reset; the illegal opcode completes as nop in 4 cycles.
